// File: rtl/ex_pkg.sv
// Shared definitions for the RV32IM execute stage: ALU op codes, operand
// select encodings and the iterative mul/div unit's state type.
package ex_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  localparam logic [1:0] SRCA_RS1 = 2'd0;
  localparam logic [1:0] SRCA_PC  = 2'd1;

  localparam logic [2:0] SRCB_RS2   = 3'd0;
  localparam logic [2:0] SRCB_IMM   = 3'd1;
  localparam logic [2:0] SRCB_UPPER = 3'd2;
  localparam logic [2:0] SRCB_FOUR  = 3'd3;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_mop(input logic [4:0] op);
    return op[4];
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_iter.sv
// Sequential M-extension unit: 32-step shift-add multiply and restoring
// divide over operand magnitudes, with the sign applied when the result is read.
module muldiv_iter
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [1:0]  state_o
);

  md_state_e   state_q;
  logic [4:0]  count_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic [31:0] a_q;
  logic        is_div_q, want_hi_q, want_rem_q, neg_a_q, neg_b_q, b_zero_q;

  logic        signed_a, signed_b, neg_a, neg_b, is_div;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [63:0] step_d, mul_full;
  logic [31:0] quo, rem;

  always_comb begin
    signed_a = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    signed_b = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    is_div   = (op_i == OP_DIV) || (op_i == OP_DIVU) || (op_i == OP_REM) || (op_i == OP_REMU);
    neg_a    = signed_a & a_i[31];
    neg_b    = signed_b & b_i[31];
    mag_a    = neg_a ? (32'd0 - a_i) : a_i;
    mag_b    = neg_b ? (32'd0 - b_i) : b_i;
  end

  // Multiply: {hi,lo} holds partial product over the shifting multiplier.
  // Divide: {hi,lo} holds partial remainder over the shifting quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_diff = {1'b0, acc_q[63:31]} - {2'b00, opb_q};
    if (is_div_q) begin
      if (!div_diff[33]) step_d = {div_diff[31:0], acc_q[30:0], 1'b1};
      else               step_d = {acc_q[62:0], 1'b0};
    end else begin
      step_d = {mul_sum, acc_q[31:1]};
    end
  end

  always_comb begin
    mul_full = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_q) : acc_q;
    quo      = acc_q[31:0];
    rem      = acc_q[63:32];
    if (is_div_q) begin
      if (b_zero_q)        result_o = want_rem_q ? a_q : 32'hFFFF_FFFF;
      else if (want_rem_q) result_o = neg_a_q ? (32'd0 - rem) : rem;
      else                 result_o = (neg_a_q ^ neg_b_q) ? (32'd0 - quo) : quo;
    end else begin
      result_o = want_hi_q ? mul_full[63:32] : mul_full[31:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MD_IDLE;
      count_q    <= 5'd0;
      acc_q      <= 64'd0;
      opb_q      <= 32'd0;
      a_q        <= 32'd0;
      is_div_q   <= 1'b0;
      want_hi_q  <= 1'b0;
      want_rem_q <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      b_zero_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_q    <= MD_BUSY;
            count_q    <= 5'd0;
            acc_q      <= {32'd0, is_div ? mag_a : mag_b};
            opb_q      <= is_div ? mag_b : mag_a;
            a_q        <= a_i;
            is_div_q   <= is_div;
            want_hi_q  <= (op_i != OP_MUL);
            want_rem_q <= (op_i == OP_REM) || (op_i == OP_REMU);
            neg_a_q    <= neg_a;
            neg_b_q    <= neg_b;
            b_zero_q   <= (b_i == 32'd0);
          end
        end
        MD_BUSY: begin
          acc_q   <= step_d;
          count_q <= count_q + 5'd1;
          if (count_q == 5'(ITER_COUNT - 1)) state_q <= MD_DONE;
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == MD_BUSY);
  assign done_o  = (state_q == MD_DONE);
  assign state_o = state_q;

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand muxes, single-cycle ALU, iterative mul/div
// and the EX/MEM output register.
module ex_stage
  import ex_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  input  logic [31:0] rs1val,
  input  logic [31:0] rs2val,
  input  logic [31:0] LoadStoreOrjalAddress,
  input  logic [31:0] auipcOrlui,
  input  logic [1:0]  ALUSourceA,
  input  logic [2:0]  ALUSourceB,
  input  logic [4:0]  ALUOp,
  input  logic        InValid,
  input  logic        Flush,
  output logic [31:0] Result,
  output logic [31:0] StoreData,
  output logic        OutValid,
  output logic        Stall
);

  logic [31:0] op_a, op_b, alu_res, md_result;
  logic [4:0]  shamt;
  logic        is_m, md_busy, md_done;
  logic [1:0]  md_state;
  logic [31:0] result_q, store_q;
  logic        valid_q;

  assign is_m  = is_mop(ALUOp);
  assign shamt = op_b[4:0];

  always_comb begin
    case (ALUSourceA)
      SRCA_RS1: op_a = rs1val;
      SRCA_PC:  op_a = PC;
      default:  op_a = 32'd0;
    endcase
    case (ALUSourceB)
      SRCB_RS2:   op_b = rs2val;
      SRCB_IMM:   op_b = LoadStoreOrjalAddress;
      SRCB_UPPER: op_b = auipcOrlui;
      SRCB_FOUR:  op_b = 32'd4;
      default:    op_b = 32'd0;
    endcase
  end

  always_comb begin
    case (ALUOp)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {31'd0, op_a < op_b};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = 32'd0;
    endcase
  end

  muldiv_iter u_muldiv (
    .clk_i    (CLK),
    .rst_i    (RST),
    .start_i  (InValid & is_m),
    .flush_i  (Flush),
    .op_i     (ALUOp),
    .a_i      (op_a),
    .b_i      (op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result),
    .state_o  (md_state)
  );

  // Stall holds ID/EX steady while an M op is in IDLE or BUSY; the cycle the
  // unit sits in DONE, Stall drops and the output register takes its result.
  // OutValid marks one cycle per retired instruction; bubbles carry OutValid=0.
  assign Stall = InValid & is_m & (md_busy | (md_state == MD_IDLE)) & ~Flush & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      result_q <= 32'd0;
      store_q  <= 32'd0;
      valid_q  <= 1'b0;
    end else if (Flush || Stall) begin
      valid_q <= 1'b0;
    end else begin
      result_q <= md_done ? md_result : alu_res;
      store_q  <= rs2val;
      valid_q  <= InValid;
    end
  end

  assign Result    = result_q;
  assign StoreData = store_q;
  assign OutValid  = valid_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, randomized ALU and M ops against
// an arithmetic reference model, and flush/reset abort sequences.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk, rst;
  logic [31:0] pc, rs1, rs2, imm, upi;
  logic [1:0]  srca;
  logic [2:0]  srcb;
  logic [4:0]  aluop;
  logic        in_valid, flush;
  logic [31:0] result, store_data;
  logic        out_valid, stall;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];

  ex_stage dut (
    .CLK(clk), .RST(rst), .PC(pc), .rs1val(rs1), .rs2val(rs2),
    .LoadStoreOrjalAddress(imm), .auipcOrlui(upi),
    .ALUSourceA(srca), .ALUSourceB(srcb), .ALUOp(aluop),
    .InValid(in_valid), .Flush(flush),
    .Result(result), .StoreData(store_data), .OutValid(out_valid), .Stall(stall)
  );

  // clock / reset support
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  srca;
    logic [2:0]  srcb;
    logic [4:0]  op;
    logic [31:0] pc, rs1, rs2, imm, upi, exp;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [1:0] sa, input logic [2:0] sb, input logic [4:0] op,
                              input logic [31:0] p, r1, r2, im, up, ex);
    vec_t v;
    v.srca = sa; v.srcb = sb; v.op = op;
    v.pc = p; v.rs1 = r1; v.rs2 = r2; v.imm = im; v.upi = up; v.exp = ex;
    return v;
  endfunction

  // reference model
  function automatic logic [31:0] sel_a(input logic [1:0] s, input logic [31:0] p, r1);
    if (s == 2'd0) return r1;
    if (s == 2'd1) return p;
    return 32'd0;
  endfunction

  function automatic logic [31:0] sel_b(input logic [2:0] s, input logic [31:0] r2, im, up);
    case (s)
      3'd0: return r2;
      3'd1: return im;
      3'd2: return up;
      3'd3: return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, b);
    longint ua, ub, sa, sb, pw, r;
    int sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    pw = 1;
    for (int i = 0; i < sh; i++) pw = pw * 2;
    r = 0;
    case (op)
      OP_ADD:  r = ua + ub;
      OP_SUB:  r = ua - ub;
      OP_SLL:  r = ua * pw;
      OP_SLT:  r = (sa < sb) ? 1 : 0;
      OP_SLTU: r = (ua < ub) ? 1 : 0;
      OP_XOR:  r = ua ^ ub;
      OP_SRL:  r = ua / pw;
      OP_SRA:  r = (sa >= 0) ? sa / pw : -((-sa + pw - 1) / pw);
      OP_OR:   r = ua | ub;
      OP_AND:  r = ua & ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_md(input logic [4:0] op, input logic [31:0] a, b);
    longint ua, ub, sa, sb, p;
    logic ovf;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      OP_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      OP_REMU:   begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
      default:   return 32'd0;
    endcase
  endfunction

  // checking helpers
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] sa, input logic [2:0] sb, input logic [4:0] op,
                       input logic [31:0] p, r1, r2, im, up);
    srca = sa; srcb = sb; aluop = op;
    pc = p; rs1 = r1; rs2 = r2; imm = im; upi = up;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    aluop    = OP_ADD;
  endtask

  // Presents one single-cycle op now (just after an edge) and checks it one cycle later.
  task automatic apply_single(input string name, input logic [1:0] sa, input logic [2:0] sb,
                              input logic [4:0] op, input logic [31:0] p, r1, r2, im, up);
    logic [31:0] e;
    drive(sa, sb, op, p, r1, r2, im, up);
    exp_q.push_back(ref_alu(op, sel_a(sa, p, r1), sel_b(sb, r2, im, up)));
    @(negedge clk);
    check32({name, " stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check32({name, " outvalid"}, {31'd0, out_valid}, 32'd1);
    check32({name, " result"}, result, e);
    check32({name, " storedata"}, store_data, r2);
  endtask

  // Presents one M op now and follows it to its result, checking the stall window.
  task automatic run_mop(input string name, input logic [4:0] op, input logic [31:0] a, b,
                         output int done_cyc);
    int stalls, ov_bad;
    logic [31:0] e;
    drive(2'd0, 3'd0, op, 32'd0, a, b, 32'd0, 32'd0);
    exp_q.push_back(ref_md(op, a, b));
    stalls = 0;
    ov_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c > 0 && out_valid) ov_bad++;
      if (!stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    check32({name, " stall cycles"}, stalls, 32'd33);
    check32({name, " early outvalid"}, ov_bad, 32'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    done_cyc = cyc;
    check32({name, " outvalid"}, {31'd0, out_valid}, 32'd1);
    check32({name, " result"}, result, e);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t1, t2;
    logic [4:0]  op;
    logic [31:0] a, b;

    vecs[0]  = mk(2'd0, 3'd1, OP_ADD,  0, 32'h10, 0, 32'h20, 0, 32'h30);
    vecs[1]  = mk(2'd1, 3'd3, OP_ADD,  32'h100, 0, 0, 0, 0, 32'h104);
    vecs[2]  = mk(2'd0, 3'd0, OP_SRA,  0, 32'h8000_0000, 32'h21, 0, 0, 32'hC000_0000);
    vecs[3]  = mk(2'd0, 3'd0, OP_SUB,  0, 32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE);
    vecs[4]  = mk(2'd0, 3'd0, OP_SLT,  0, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1);
    vecs[5]  = mk(2'd0, 3'd0, OP_SLTU, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0);
    vecs[6]  = mk(2'd0, 3'd0, OP_XOR,  0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 32'hFF00_FF00);
    vecs[7]  = mk(2'd0, 3'd0, OP_OR,   0, 32'h1234_0000, 32'h0000_5678, 0, 0, 32'h1234_5678);
    vecs[8]  = mk(2'd0, 3'd0, OP_AND,  0, 32'hFFFF_0000, 32'h1234_5678, 0, 0, 32'h1234_0000);
    vecs[9]  = mk(2'd0, 3'd0, OP_SRL,  0, 32'h8000_0000, 32'h1F, 0, 0, 32'd1);
    vecs[10] = mk(2'd0, 3'd0, OP_SLL,  0, 32'd1, 32'h24, 0, 0, 32'h10);
    vecs[11] = mk(2'd2, 3'd2, OP_ADD,  32'h500, 32'h77, 0, 0, 32'hABCD_E000, 32'hABCD_E000);
    vecs[12] = mk(2'd1, 3'd2, OP_ADD,  32'h1000, 0, 0, 0, 32'h2000, 32'h3000);
    vecs[13] = mk(2'd0, 3'd5, OP_ADD,  0, 32'h55, 32'h99, 32'h66, 0, 32'h55);
    vecs[14] = mk(2'd3, 3'd4, OP_OR,   32'h9, 32'h1234, 32'h5, 32'h8, 32'h7, 32'h0);

    // reset with an M op on the inputs: Stall must stay low
    rst = 1'b1; flush = 1'b0;
    drive(2'd0, 3'd0, OP_MUL, 0, 32'd3, 32'd5, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check32("reset result", result, 32'd0);
    check32("reset storedata", store_data, 32'd0);
    check32("reset outvalid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check32("reset stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      apply_single($sformatf("vec%0d", i), vecs[i].srca, vecs[i].srcb, vecs[i].op,
                   vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].upi);
    n_tests += 0;
    for (int i = 0; i < 15; i++)
      check32($sformatf("vec%0d model", i),
              ref_alu(vecs[i].op, sel_a(vecs[i].srca, vecs[i].pc, vecs[i].rs1),
                      sel_b(vecs[i].srcb, vecs[i].rs2, vecs[i].imm, vecs[i].upi)), vecs[i].exp);

    idle();
    @(posedge clk); #1;
    check32("idle outvalid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 40; i++)
      apply_single($sformatf("rnd_alu%0d", i), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   5'($urandom_range(0, 9)), $urandom, pick(), $urandom, $urandom, $urandom);

    run_mop("mulh_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t1);
    idle();
    @(posedge clk); #1;
    check32("mulh single pulse", {31'd0, out_valid}, 32'd0);

    run_mop("div_by_zero", OP_DIV, 32'd7, 32'd0, t1);
    run_mop("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, t1);

    run_mop("divu_100_7", OP_DIVU, 32'd100, 32'd7, t1);
    run_mop("remu_100_7", OP_REMU, 32'd100, 32'd7, t2);
    check32("back-to-back spacing", t2 - t1, 32'd34);

    // flush during iteration 10
    drive(2'd0, 3'd0, OP_DIV, 0, 32'd1000, 32'd3, 0, 0);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check32("flush stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check32("flush outvalid", {31'd0, out_valid}, 32'd0);
    apply_single("post_flush_add", 2'd0, 3'd1, OP_ADD, 0, 32'd3, 0, 32'd4, 0);
    run_mop("post_flush_mul", OP_MUL, 32'd6, 32'd7, t1);

    // reset during iteration 20
    drive(2'd0, 3'd0, OP_REMU, 0, 32'h1234_5678, 32'h1000, 0, 0);
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check32("rst stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check32("rst outvalid", {31'd0, out_valid}, 32'd0);
    check32("rst result", result, 32'd0);
    check32("rst storedata", store_data, 32'd0);
    apply_single("post_rst_add", 2'd0, 3'd1, OP_ADD, 0, 32'h40, 0, 32'h2, 0);
    run_mop("post_rst_divu", OP_DIVU, 32'h1234_5678, 32'h1000, t1);

    for (int i = 0; i < 8; i++) begin
      op = 5'(16 + $urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_mop($sformatf("rnd_md%0d op%0d", i, op), op, a, b, t1);
    end

    idle();
    @(posedge clk); #1;
    check32("scoreboard drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RV32IM pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its registered outputs: PC, rs1/rs2 values, immediate/address operand, auipc/lui operand, and the operand-select codes. It computes the ALU result, or the multiply/divide result for M-extension ops through a 32-iteration sequential unit, and registers it for the EX/MEM boundary. While a multi-cycle op runs, it stalls the upstream stages.

## Interface
- No parameters; data width fixed at 32.
- CLK  in  1  pipeline clock, single clock domain, all state on posedge.
- RST  in  1  synchronous, active-high reset.
- PC  in  32  instruction address from ID/EX.
- rs1val, rs2val  in  32  register operands from ID/EX.
- LoadStoreOrjalAddress  in  32  immediate/address operand from ID/EX.
- auipcOrlui  in  32  upper-immediate operand from ID/EX.
- ALUSourceA  in  2  operand A select: 0=rs1val, 1=PC, 2/3=zero.
- ALUSourceB  in  3  operand B select: 0=rs2val, 1=LoadStoreOrjalAddress, 2=auipcOrlui, 3=constant 4, 4..7=zero.
- ALUOp  in  5  operation code (ex_pkg).
- InValid  in  1  ID/EX holds a real instruction.
- Flush  in  1  kill the current EX op (branch redirect).
- Result  out  32  registered result.
- StoreData  out  32  registered copy of rs2val.
- OutValid  out  1  Result/StoreData valid this cycle.
- Stall  out  1  combinational; freezes PC, IF/ID and ID/EX while high.

## Operation
- Operands A and B are selected combinationally per the encodings above.
- Single-cycle ops:
  - ADD, SUB, AND, OR, XOR.
  - SLL, SRL, SRA: shift amount is B[4:0].
  - SLT, SLTU: result is 0 or 1, zero-extended.
- Multi-cycle ops:
  - MUL, MULH, MULHSU, MULHU: shift-add over magnitudes, sign fixed at the end.
  - DIV, DIVU, REM, REMU: restoring division over magnitudes.
- Sub-module FSM states are IDLE, BUSY and DONE.
  - IDLE to BUSY: InValid and an M op. On this transition the unit latches operands and op, and clears the iteration counter.
  - BUSY: one iteration per cycle. After iteration 31 completes, go to DONE.
  - DONE: result available. Go to IDLE on the next edge.
- Stall = InValid & M op & state!=DONE & !Flush & !RST.
- Output register update:
  - Stall low: Result and StoreData capture; OutValid <= InValid.
  - Stall high: OutValid <= 0, i.e. a bubble; Result and StoreData hold.
- Divide special cases:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
  - Special cases take the full latency, so latency is deterministic.
- Flush has priority over everything except RST:
  - FSM goes to IDLE and OutValid <= 0 at the next edge.
  - Stall is forced low in the same cycle.
- RST: FSM IDLE, counter 0, Result 0, StoreData 0, OutValid 0. Stall reads 0 while RST is high.

## Timing
- Single-cycle op presented in cycle t: Result/OutValid valid in cycle t+1.
- M op presented in cycle t:
  - Stall high in cycles t..t+32, low in t+33.
  - Result captured at the end of t+33; OutValid high in t+34.
  - OutValid is 0 in cycles t+1..t+33.
- Back-to-back M ops: the second op enters IDLE-to-BUSY in the cycle after DONE. There is no dead cycle beyond DONE.
- Reset or Flush in any BUSY cycle aborts the op; no partial result is ever output.
- InValid low in IDLE: no state change, OutValid <= 0.

## Structure
- Package ex_pkg holds:
  - ALUOp codes: ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND=9, MUL=16, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU=23. Bit 4 set means M op.
  - ALUSourceA/ALUSourceB encodings.
  - Iteration count constant 32.
- One sub-module, muldiv_iter: the FSM, counter, and shift/accumulate datapath. It exposes start, op, a, b, flush, busy, done, result.
- ex_stage holds the operand muxes, the combinational ALU, the Stall logic and the output register.

## Test plan
- ALUSourceA=0, ALUSourceB=1, ADD, rs1val=0x10, LoadStoreOrjalAddress=0x20 -> Result=0x30 one cycle later, OutValid=1, Stall never high.
- ALUSourceA=1, ALUSourceB=3, ADD, PC=0x100 -> Result=0x104. Then SRA with rs1val=0x80000000, rs2val=0x21 -> Result=0xC0000000 (shift by 1).
- MULH with rs1val=0xFFFFFFFF, rs2val=0xFFFFFFFF -> Stall high 33 cycles, Result=0x00000000, OutValid high exactly once.
- DIV with rs2val=0 and rs1val=7 -> Result=0xFFFFFFFF. REM with rs1val=0x80000000, rs2val=0xFFFFFFFF -> Result=0. Each takes 34-cycle latency.
- DIVU 100/7 back-to-back with REMU 100/7 -> results 14 then 2, with OutValid pulses 34 cycles apart.
- Flush asserted at BUSY iteration 10, and separately RST at iteration 20 -> Stall low in that cycle, OutValid 0, FSM IDLE. A following ADD completes in 1 cycle.
